// File: rtl/stream_fifo.sv
// stream_fifo: parameterised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, synchronous flush and sticky error flags.
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter bit FWFT       = 1'b0,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count_q, count_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic live, write_ok, read_ok;
    assign empty        = w_ptr_q == r_ptr_q;
    assign full         = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) && (w_ptr_q[AW] != r_ptr_q[AW]);
    assign count        = count_q;
    assign almost_full  = count_q >= AF_CNT;
    assign almost_empty = count_q <= AE_CNT;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    // rst and flush both swallow any request presented on their edge
    assign live     = ~rst & ~flush;
    assign write_ok = live & we & ~full;
    assign read_ok  = live & re & ~empty;
    always_comb begin
        w_ptr_d = w_ptr_q + (AW+1)'(write_ok);
        r_ptr_d = r_ptr_q + (AW+1)'(read_ok);
        count_d = (write_ok & ~read_ok) ? count_q + 1'b1 :
                  (read_ok & ~write_ok) ? count_q - 1'b1 : count_q;
        ovf_d   = ovf_q | (we & full);
        unf_d   = unf_q | (re & empty);
    end
    always_ff @(posedge clk) begin
        if (rst | flush) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (write_ok) mem_q[w_ptr_q[AW-1:0]] <= w_data;
    end
    generate
        if (FWFT) begin : g_fwft
            assign r_valid = ~empty;
            assign r_data  = empty ? '0 : mem_q[r_ptr_q[AW-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_data_q;
            logic                  r_valid_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= read_ok;
                    if (read_ok) r_data_q <= mem_q[r_ptr_q[AW-1:0]];
                end
            end
            assign r_valid = r_valid_q;
            assign r_data  = r_data_q;
        end
    endgenerate
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: drives a registered-read and an FWFT instance with identical directed stimulus
// and checks both every cycle against a queue-based model, plus literal spot checks.
module tb_stream_fifo;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] rd0, rd1;
    logic [3:0] cnt0, cnt1;
    logic rv0, emp0, ful0, af0, ae0, ov0, un0;
    logic rv1, emp1, ful1, af1, ae1, ov1, un1;
    int checks = 0, errors = 0;
    bit chk_on = 1'b0;
    logic [7:0] q[$];
    bit m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;

    always #5 clk = ~clk;

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b0), .AF_LEVEL(4), .AE_LEVEL(2)) d0 (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .w_data(w_data), .re(re),
        .r_data(rd0), .r_valid(rv0), .empty(emp0), .full(ful0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0));
    stream_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b1), .AF_LEVEL(4), .AE_LEVEL(2)) d1 (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .w_data(w_data), .re(re),
        .r_data(rd1), .r_valid(rv1), .empty(emp1), .full(ful1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a queue of stored words, updated from pre-edge occupancy
    always @(posedge clk) begin
        if (rst) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'h00;
        end else if (flush) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0;
        end else begin
            automatic bit was_full = q.size() == 8;
            automatic bit was_empty = q.size() == 0;
            if (we && was_full) m_ovf = 1;
            if (re && was_empty) m_unf = 1;
            m_rv = re && !was_empty;
            if (m_rv) m_rd = q.pop_front();
            if (we && !was_full) q.push_back(w_data);
        end
    end

    always @(negedge clk) if (chk_on) begin
        automatic int n = q.size();
        chk("count0", 32'(cnt0), n);
        chk("count1", 32'(cnt1), n);
        chk("empty0", 32'(emp0), 32'(n == 0));
        chk("full0", 32'(ful0), 32'(n == 8));
        chk("af0", 32'(af0), 32'(n >= 4));
        chk("ae0", 32'(ae0), 32'(n <= 2));
        chk("empty1", 32'(emp1), 32'(n == 0));
        chk("full1", 32'(ful1), 32'(n == 8));
        chk("ovf0", 32'(ov0), 32'(m_ovf));
        chk("unf0", 32'(un0), 32'(m_unf));
        chk("ovf1", 32'(ov1), 32'(m_ovf));
        chk("unf1", 32'(un1), 32'(m_unf));
        chk("rvalid0", 32'(rv0), 32'(m_rv));
        chk("rdata0", 32'(rd0), 32'(m_rd));
        chk("rvalid1", 32'(rv1), 32'(n != 0));
        if (n != 0) chk("rdata1", 32'(rd1), 32'(q[0]));
    end

    initial begin
        tick(); tick();
        rst = 0; chk_on = 1;
        chk("rst_empty", 32'(emp0), 1); chk("rst_count", 32'(cnt0), 0);
        chk("rst_ae", 32'(ae0), 1); chk("rst_af", 32'(af0), 0);
        chk("rst_rdata", 32'(rd0), 0); chk("rst_rvalid", 32'(rv0), 0);
        // fill then drain, registered read
        for (int i = 0; i < 8; i++) begin
            we = 1; w_data = 8'h10 + 8'(i); tick();
            chk("fill_count", 32'(cnt0), i + 1);
            chk("fill_af", 32'(af0), 32'(i >= 3));
        end
        we = 0;
        chk("fill_full", 32'(ful0), 1);
        for (int i = 0; i < 8; i++) begin
            re = 1; tick();
            chk("drain_rv", 32'(rv0), 1);
            chk("drain_rd", 32'(rd0), 32'h10 + i);
        end
        re = 0; tick();
        chk("drain_rv_off", 32'(rv0), 0);
        chk("drain_empty", 32'(emp0), 1);
        // simultaneous access at full
        for (int i = 0; i < 8; i++) begin we = 1; w_data = 8'h20 + 8'(i); tick(); end
        we = 1; w_data = 8'hAA; re = 1; tick();
        chk("fullsim_count", 32'(cnt0), 7); chk("fullsim_ovf", 32'(ov0), 1);
        chk("fullsim_rd", 32'(rd0), 32'h20);
        we = 0; re = 0; tick();
        chk("ovf_sticky", 32'(ov0), 1);
        re = 1; repeat (7) tick(); re = 0;
        chk("fullsim_last", 32'(rd0), 32'h27);
        tick();
        // simultaneous access at empty
        we = 1; w_data = 8'h55; re = 1; tick();
        chk("emptysim_count", 32'(cnt0), 1); chk("emptysim_unf", 32'(un0), 1);
        chk("emptysim_rv", 32'(rv0), 0);
        we = 0; tick();
        chk("emptysim_rd", 32'(rd0), 32'h55); chk("emptysim_rv2", 32'(rv0), 1);
        re = 0; flush = 1; tick(); flush = 0;
        chk("flush_unf", 32'(un0), 0); chk("flush_ovf", 32'(ov0), 0);
        // first-word-fall-through presentation
        we = 1; w_data = 8'h3C; tick();
        chk("fwft_rv", 32'(rv1), 1); chk("fwft_rd", 32'(rd1), 32'h3C); chk("fwft_c1", 32'(cnt1), 1);
        w_data = 8'h3D; tick();
        chk("fwft_c2", 32'(cnt1), 2); chk("fwft_head", 32'(rd1), 32'h3C);
        we = 0; re = 1; tick();
        chk("fwft_next", 32'(rd1), 32'h3D); chk("fwft_c3", 32'(cnt1), 1);
        tick(); re = 0;
        chk("fwft_rv_off", 32'(rv1), 0);
        // pointer wrap-around
        for (int i = 0; i < 27; i++) begin
            we = 1; w_data = 8'h40 + 8'(i); tick();
            we = 0; re = 1; tick(); re = 0;
            chk("wrap_rd", 32'(rd0), 32'h40 + i);
        end
        chk("wrap_ovf", 32'(ov0), 0); chk("wrap_unf", 32'(un0), 0);
        // flush with a write pending, then reset with a read pending
        for (int i = 0; i < 9; i++) begin we = 1; w_data = 8'h60 + 8'(i); tick(); end
        we = 0; re = 1; repeat (3) tick(); re = 0;
        chk("pre_flush_count", 32'(cnt0), 5); chk("pre_flush_ovf", 32'(ov0), 1);
        flush = 1; we = 1; w_data = 8'hEE; tick(); flush = 0; we = 0;
        chk("flush_count", 32'(cnt0), 0); chk("flush_empty", 32'(emp0), 1);
        chk("flush_ovf2", 32'(ov0), 0);
        we = 1; w_data = 8'h71; tick(); w_data = 8'h72; tick(); we = 0;
        re = 1; rst = 1; tick(); re = 0; rst = 0;
        chk("rst_rv0", 32'(rv0), 0); chk("rst_rv1", 32'(rv1), 0);
        chk("rst_cnt", 32'(cnt0), 0); chk("rst_rd", 32'(rd0), 0);
        chk("rst_full", 32'(ful0), 0); chk("rst_af2", 32'(af0), 0);
        chk("rst_ae2", 32'(ae0), 1); chk("rst_unf", 32'(un0), 0);
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parameterised synchronous FIFO, single clock. Successor to the team's basic 8-bit/256-deep FIFO. Adds the following over that block:
- selectable read mode: registered read, or first-word-fall-through (FWFT)
- occupancy count
- programmable almost-full / almost-empty flags
- synchronous flush
- sticky overflow / underflow error flags

Sits between the host byte stream and the systolic array input/output staging. Used wherever a producer and a consumer need elastic buffering with back-pressure visibility.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits
DEPTH, 256, number of storage entries; must be a power of two, at least 2
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock, only clock in the block
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents; data and control only, parameters unaffected
we  input  1  write request
w_data  input  DATA_WIDTH  write data
re  input  1  read request (FWFT=1: pop/acknowledge of the head word)
r_data  output  DATA_WIDTH  read data
r_valid  output  1  r_data holds a valid word
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  number of words currently stored
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
Storage and pointers:
- Memory array of DEPTH x DATA_WIDTH.
- Read and write pointers are $clog2(DEPTH)+1 bits wide, carrying an extra wrap MSB.
- empty = (pointers equal). full = (low bits equal and MSBs differ).
- count is a registered counter; it must always equal w_ptr - r_ptr, modulo 2*DEPTH.

Accept rules (evaluated on pre-edge state):
- write_ok = we & !full
- read_ok = re & !empty
- A read in the same cycle does NOT free a slot for a write when full.
- A write in the same cycle does NOT satisfy a read when empty.

Count update:
- write_ok only: +1
- read_ok only: -1
- both, or neither: unchanged
- Wrap-around is transparent: pointers roll from 2*DEPTH-1 to 0.

Read mode FWFT=0:
- On read_ok, r_data is loaded at the clock edge with mem[r_ptr], and r_valid is 1 for exactly the following cycle.
- Otherwise r_valid = 0 and r_data holds its last value.

Read mode FWFT=1:
- r_data = mem[r_ptr], combinational from storage; r_valid = !empty.
- The first word is visible the cycle after the write edge that stores it.
- re while r_valid pops the word at the edge, and the next word is presented immediately.
- re while !r_valid counts as underflow.

Flags:
- almost_full, almost_empty, empty and full are all derived from the registered count/pointers, so they are glitch-free and valid from the cycle after reset.
- overflow sets on (we & full); underflow sets on (re & empty).
- Both are sticky until rst or flush.
- A rejected access changes no other state.

Flush:
- Next edge: pointers = 0, count = 0, r_valid = 0, overflow = underflow = 0.
- Memory contents are not cleared.
- flush has priority over we/re in the same cycle; both requests are dropped and are not flagged.

Reset:
- rst has priority over everything.
- After the edge: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, r_valid 0, r_data 0, overflow 0, underflow 0.
- Reset mid-stream discards all stored words; a read pending on that edge produces no r_valid.

Test Plan:
1. Reset, then DEPTH=8, FWFT=0. Write 8 words 0x10..0x17. Expect full=1 and count=8 after the 8th edge, almost_full=1 from count 4 (AF_LEVEL=4). Read 8: r_data 0x10..0x17, each with r_valid one cycle after re. Expect empty=1 at the end.
2. Full-boundary simultaneity: with count=8, assert we=1 (0xAA) and re=1 together. Expect the read accepted, write rejected, count=7, overflow=1 and stays 1. 0xAA never appears on r_data.
3. Empty-boundary simultaneity: with count=0, assert we=1 (0x55) and re=1 together. Expect count=1, underflow=1, no r_valid that cycle. The next read returns 0x55.
4. FWFT=1: write 0x3C at edge N. Expect r_valid=1 and r_data=0x3C after edge N. Then write 0x3D and pop with re. Expect 0x3D presented in the cycle after the pop, with count tracking 1 → 2 → 1.
5. Wrap-around: 3*DEPTH+3 interleaved write/read pairs with incrementing data. Expect every read equal to the expected sequence, count never above DEPTH, and no overflow/underflow.
6. Flush and reset mid-operation: with count=5 and overflow=1, assert flush together with we. Next cycle expect count=0, empty=1, overflow=0 and the write dropped. Repeat with rst while re is pending: no r_valid, and all outputs at their reset values.
